// File: rtl/ntt_stage_counter.sv
// NTT stage sequencer: counts CNT_MAX+1 cycles per stage across NUM_STAGES stages,
// pulsing stage_done at each stage boundary and all_done at the end of the run.
module ntt_stage_counter #(
    parameter int unsigned CNT_W        = 6,
    parameter int unsigned CNT_MAX      = 63,
    parameter int unsigned STG_W        = 4,
    parameter int unsigned NUM_STAGES   = 9,
    parameter bit          AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_start,
    input  logic             in_abort,
    input  logic             in_hold,
    output logic [CNT_W-1:0] counter_out,
    output logic [STG_W-1:0] stage_out,
    output logic             busy,
    output logic             stage_done,
    output logic             all_done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CNT_MAX);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_d;
    logic [STG_W-1:0] stg_d;
    logic             sd_d, ad_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = counter_out;
        stg_d   = stage_out;
        sd_d    = 1'b0;
        ad_d    = 1'b0;
        if (in_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            stg_d   = '0;
        end else if (in_start) begin
            // restart wins over a terminal count in the same cycle
            state_d = RUN;
            cnt_d   = '0;
            stg_d   = '0;
        end else if (state_q == IDLE) begin
            cnt_d = '0;
            stg_d = '0;
        end else if (!in_hold) begin
            if (counter_out == CNT_TERM) begin
                cnt_d = '0;
                sd_d  = 1'b1;
                if (stage_out == STG_LAST) begin
                    stg_d = '0;
                    ad_d  = 1'b1;
                    if (!AUTO_RESTART) state_d = IDLE;
                end else begin
                    stg_d = stage_out + 1'b1;
                end
            end else begin
                cnt_d = counter_out + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            counter_out <= '0;
            stage_out   <= '0;
            busy        <= 1'b0;
            stage_done  <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_out <= cnt_d;
            stage_out   <= stg_d;
            busy        <= (state_d == RUN);
            stage_done  <= sd_d;
            all_done    <= ad_d;
        end
    end

endmodule

// File: tb/tb_ntt_stage_counter.sv
// Randomized check of three ntt_stage_counter configurations against a
// position-based reference model (pos = stage*(CNT_MAX+1) + counter).
module tb_ntt_stage_counter;

    logic clk = 1'b0;
    logic rst, in_start, in_abort, in_hold;
    always #5 clk = ~clk;

    logic [5:0] c0, c1;
    logic [3:0] c2;
    logic [3:0] s0, s1, s2;
    logic       b0, b1, b2, sd0, sd1, sd2, ad0, ad1, ad2;

    ntt_stage_counter u_def (
        .clk(clk), .rst(rst), .in_start(in_start), .in_abort(in_abort), .in_hold(in_hold),
        .counter_out(c0), .stage_out(s0), .busy(b0), .stage_done(sd0), .all_done(ad0));

    ntt_stage_counter #(.AUTO_RESTART(1'b1)) u_auto (
        .clk(clk), .rst(rst), .in_start(in_start), .in_abort(in_abort), .in_hold(in_hold),
        .counter_out(c1), .stage_out(s1), .busy(b1), .stage_done(sd1), .all_done(ad1));

    ntt_stage_counter #(.CNT_W(4), .CNT_MAX(9), .NUM_STAGES(1)) u_small (
        .clk(clk), .rst(rst), .in_start(in_start), .in_abort(in_abort), .in_hold(in_hold),
        .counter_out(c2), .stage_out(s2), .busy(b2), .stage_done(sd2), .all_done(ad2));

    int LEN [3] = '{64, 64, 10};
    int NST [3] = '{9, 9, 1};
    bit AUTO[3] = '{1'b0, 1'b1, 1'b0};

    int pos [3];
    bit run [3];
    bit m_sd[3];
    bit m_ad[3];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_step(input int i, input bit r, input bit a, input bit s, input bit h);
        m_sd[i] = 1'b0;
        m_ad[i] = 1'b0;
        if (r || a) begin
            run[i] = 1'b0;
            pos[i] = 0;
        end else if (s) begin
            run[i] = 1'b1;
            pos[i] = 0;
        end else if (run[i] && !h) begin
            pos[i]++;
            if (pos[i] % LEN[i] == 0) m_sd[i] = 1'b1;
            if (pos[i] == LEN[i] * NST[i]) begin
                m_ad[i] = 1'b1;
                pos[i]  = 0;
                run[i]  = AUTO[i];
            end
        end
    endfunction

    task automatic check_all();
        check("def.cnt",   32'(c0),  32'(pos[0] % LEN[0]));
        check("def.stg",   32'(s0),  32'(pos[0] / LEN[0]));
        check("def.busy",  32'(b0),  32'(run[0]));
        check("def.sdone", 32'(sd0), 32'(m_sd[0]));
        check("def.adone", 32'(ad0), 32'(m_ad[0]));
        check("auto.cnt",   32'(c1),  32'(pos[1] % LEN[1]));
        check("auto.stg",   32'(s1),  32'(pos[1] / LEN[1]));
        check("auto.busy",  32'(b1),  32'(run[1]));
        check("auto.sdone", 32'(sd1), 32'(m_sd[1]));
        check("auto.adone", 32'(ad1), 32'(m_ad[1]));
        check("small.cnt",   32'(c2),  32'(pos[2] % LEN[2]));
        check("small.stg",   32'(s2),  32'(pos[2] / LEN[2]));
        check("small.busy",  32'(b2),  32'(run[2]));
        check("small.sdone", 32'(sd2), 32'(m_sd[2]));
        check("small.adone", 32'(ad2), 32'(m_ad[2]));
    endtask

    // inputs change at negedge, DUT and model advance on posedge, compare at next negedge
    task automatic step(input bit r, input bit a, input bit s, input bit h);
        rst = r; in_abort = a; in_start = s; in_hold = h;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, r, a, s, h);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_to_pos(input int target);
        int guard = 0;
        while (pos[0] != target && guard < 2000) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check("reach_pos", 32'(pos[0]), 32'(target));
    endtask

    initial begin
        rst = 1'b1; in_start = 1'b0; in_abort = 1'b0; in_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pos[i] = 0; run[i] = 1'b0; m_sd[i] = 1'b0; m_ad[i] = 1'b0;
        end
        @(negedge clk);
        // reset with start high must still leave everything cleared
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // full run, no hold
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 600; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // hold for 10 cycles in stage 2, then hold while idle
        step(1'b0, 1'b0, 1'b1, 1'b0);
        run_to_pos(2 * 64 + 5);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 700; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // restart exactly on a terminal count (stage 3, counter 63)
        step(1'b0, 1'b0, 1'b1, 1'b0);
        run_to_pos(3 * 64 + 63);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        // hold on a terminal count
        run_to_pos(63);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // abort together with start mid-run, then reset mid-run
        for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        run_to_pos(63);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // random traffic
        for (int k = 0; k < 20000; k++) begin
            step($urandom_range(2999) == 0,
                 $urandom_range(799) == 0,
                 $urandom_range(699) == 0,
                 $urandom_range(7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_stage_counter.md
NTT_STAGE_COUNTER -- requirements
Module: ntt_stage_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 6, meaning the cycle-counter width in bits.
REQ-002 The block SHALL have parameter CNT_MAX, default 63, meaning the terminal count per stage; CNT_MAX SHALL be at most 2^CNT_W-1.
REQ-003 The block SHALL have parameter STG_W, default 4, meaning the stage-index width in bits.
REQ-004 The block SHALL have parameter NUM_STAGES, default 9, meaning the stages per run; NUM_STAGES SHALL be between 1 and 2^STG_W.
REQ-005 The block SHALL have parameter AUTO_RESTART, default 0; 1 means loop through the stages continuously, 0 means one-shot.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port in_start, input, 1 bit: start or restart a run.
REQ-009 Port in_abort, input, 1 bit: terminate the run without done pulses.
REQ-010 Port in_hold, input, 1 bit: freeze counting while high.
REQ-011 Port counter_out, output, CNT_W bits: cycle index within the current stage.
REQ-012 Port stage_out, output, STG_W bits: current stage index.
REQ-013 Port busy, output, 1 bit: high while in state RUN.
REQ-014 Port stage_done, output, 1 bit: one-cycle pulse on completion of each stage.
REQ-015 Port all_done, output, 1 bit: one-cycle pulse on completion of the last stage.

Function
REQ-016 The block SHALL implement two states, IDLE and RUN, and all outputs SHALL be registered.
REQ-017 Per-edge priority SHALL be: rst, then in_abort, then in_start, then normal counting.
REQ-018 When in_abort is high, the next state SHALL be IDLE, with counter_out=0, stage_out=0 and no stage_done or all_done pulse.
REQ-019 When in_start is high and in_abort is low, in any state, the next state SHALL be RUN, with counter_out=0, stage_out=0 and no done pulses, even if counter_out==CNT_MAX that cycle.
REQ-020 In RUN with in_hold low and counter_out<CNT_MAX, counter_out SHALL increment by 1.
REQ-021 In RUN with in_hold high, counter_out, stage_out and the state SHALL hold, and no pulse SHALL be generated; this applies at counter_out==CNT_MAX as well.
REQ-022 In RUN with in_hold low, counter_out==CNT_MAX and stage_out<NUM_STAGES-1: next counter_out=0, stage_out+1, and stage_done=1 for exactly one cycle.
REQ-023 In RUN with in_hold low, counter_out==CNT_MAX and stage_out==NUM_STAGES-1: next counter_out=0, stage_out=0, and stage_done=1 and all_done=1 for exactly one cycle.
REQ-024 At the REQ-023 event, the next state SHALL be IDLE if AUTO_RESTART=0, and SHALL remain RUN if AUTO_RESTART=1.
REQ-025 In IDLE, counter_out and stage_out SHALL hold 0, and in_hold SHALL be ignored.
REQ-026 stage_done and all_done SHALL be 0 on every edge not covered by REQ-022 or REQ-023.
REQ-027 Counter arithmetic SHALL be unsigned with explicit compare to CNT_MAX, and SHALL never rely on natural CNT_W overflow.
REQ-028 busy SHALL equal (state==RUN) as a registered value.

Reset
REQ-029 With rst high on an edge, the next state SHALL be IDLE, with counter_out=0, stage_out=0, busy=0, stage_done=0 and all_done=0, regardless of other inputs.
REQ-030 A reset mid-run SHALL discard progress, and no done pulse SHALL be produced on that edge.

Verification
REQ-031 Default parameters, in_start for 1 cycle at edge E0 -> busy=1 from E0; counter_out=k after E(k); stage_done pulses after E64, E128, ... E576; all_done and busy=0 after E576; stage_out=0.
REQ-032 AUTO_RESTART=1, same stimulus -> all_done after E576; busy stays 1; stage_out=0; counter_out=1 after E577; next all_done after E1152.
REQ-033 in_hold high for 10 cycles during stage 2 -> counter_out and stage_out frozen for those cycles; all_done after E586; in_hold in IDLE has no effect.
REQ-034 in_start asserted when stage_out=3 and counter_out=63 -> next cycle counter_out=0, stage_out=0, busy=1, stage_done=0.
REQ-035 in_abort and in_start high together mid-run -> next cycle IDLE, all outputs 0, no pulses; rst high with in_start high -> all outputs 0.
REQ-036 CNT_W=4, CNT_MAX=9, NUM_STAGES=1 -> counter sequence 0..9 then 0; stage_done and all_done coincide after E10; stage_out always 0.
